// File: rtl/dlx_bus_master.sv
// DLX memory-bus master: turns the controller's REQ/MR/MW strobes into one
// address-strobe / acknowledge bus cycle per request, returns busy to the
// controller, holds read data, and flags slaves that never acknowledge.
module dlx_bus_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  // controller side
  input  logic          REQ,
  input  logic          MR,
  input  logic          MW,
  input  logic [AW-1:0] ADDR_IN,
  input  logic [DW-1:0] WDATA_IN,
  output logic          busy,
  output logic [DW-1:0] RDATA_o,
  output logic          ERR_o,
  // bus side
  output logic [AW-1:0] AO,
  output logic [DW-1:0] DO,
  input  logic [DW-1:0] DI,
  output logic          AS_N,
  output logic          WR_N,
  input  logic          ACK_N,
  output logic [1:0]    STATE_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ao_q, ao_d;
  logic [DW-1:0] do_q, do_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          as_n_q, as_n_d;
  logic          wr_n_q, wr_n_d;
  logic          err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;

  // MR carries no information beyond MW: anything that is not a write is a read.
  logic unused_mr;
  assign unused_mr = MR;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  // Next-state and bus-register updates; defaults hold every register.
  always_comb begin
    state_d = state_q;
    ao_d    = ao_q;
    do_d    = do_q;
    rdata_d = rdata_q;
    as_n_d  = as_n_q;
    wr_n_d  = wr_n_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // A still-asserted acknowledge from the previous cycle blocks the start.
        if (REQ && ACK_N) begin
          ao_d    = ADDR_IN;
          do_d    = WDATA_IN;
          as_n_d  = 1'b0;
          wr_n_d  = ~MW;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!ACK_N) begin
          if (wr_n_q) rdata_d = DI;
          as_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Forced completion: read data is left untouched.
          err_d   = 1'b1;
          as_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        as_n_d  = 1'b1;
        wr_n_d  = 1'b1;
      end
    endcase
  end

  // State and bus registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ao_q    <= '0;
      do_q    <= '0;
      rdata_q <= '0;
      as_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ao_q    <= ao_d;
      do_q    <= do_d;
      rdata_q <= rdata_d;
      as_n_q  <= as_n_d;
      wr_n_q  <= wr_n_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // busy drops only in the completion cycle, so the controller captures then.
  assign busy    = REQ && (state_q != ST_DONE);
  assign RDATA_o = rdata_q;
  assign ERR_o   = err_q;
  assign AO      = ao_q;
  assign DO      = do_q;
  assign AS_N    = as_n_q;
  assign WR_N    = wr_n_q;
  assign STATE_o = state_q;

endmodule

// File: tb/tb_dlx_bus_master.sv
// Directed bench for dlx_bus_master: read, delayed write, timeout, stale
// acknowledge, back-to-back fetch/load and reset during a bus cycle.
module tb_dlx_bus_master;

  logic        CLK = 1'b0;
  logic        RESET, REQ, MR, MW, ACK_N;
  logic [31:0] ADDR_IN, WDATA_IN, DI;
  logic        busy, ERR_o, AS_N, WR_N;
  logic [31:0] RDATA_o, AO, DO;
  logic [1:0]  STATE_o;

  int n_chk = 0;
  int n_err = 0;

  dlx_bus_master #(.AW(32), .DW(32), .TIMEOUT(16), .TW(5)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .MR(MR), .MW(MW),
    .ADDR_IN(ADDR_IN), .WDATA_IN(WDATA_IN), .busy(busy),
    .RDATA_o(RDATA_o), .ERR_o(ERR_o), .AO(AO), .DO(DO), .DI(DI),
    .AS_N(AS_N), .WR_N(WR_N), .ACK_N(ACK_N), .STATE_o(STATE_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; REQ = 1'b0; MR = 1'b0; MW = 1'b0; ACK_N = 1'b1;
    ADDR_IN = '0; WDATA_IN = '0; DI = '0;
    tick(); tick();
    RESET = 1'b0;
    #1;
    chk("rst_state", 32'(STATE_o), 32'd0);
    chk("rst_as_n",  32'(AS_N), 32'd1);
    chk("rst_wr_n",  32'(WR_N), 32'd1);
    chk("rst_ao",    AO, 32'd0);
    chk("rst_do",    DO, 32'd0);
    chk("rst_rdata", RDATA_o, 32'd0);
    chk("rst_err",   32'(ERR_o), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);

    // Read, acknowledged in the first WAIT cycle.
    tick();
    REQ = 1'b1; MR = 1'b1; MW = 1'b0; ADDR_IN = 32'h0000_0040; DI = 32'h8C22_0004;
    #1 chk("rd_busy_c0", 32'(busy), 32'd1);
    tick();
    chk("rd_state_c1", 32'(STATE_o), 32'd1);
    chk("rd_as_n_c1",  32'(AS_N), 32'd0);
    chk("rd_wr_n_c1",  32'(WR_N), 32'd1);
    chk("rd_ao_c1",    AO, 32'h40);
    chk("rd_busy_c1",  32'(busy), 32'd1);
    ACK_N = 1'b0;
    tick();
    chk("rd_state_c2", 32'(STATE_o), 32'd2);
    chk("rd_busy_c2",  32'(busy), 32'd0);
    chk("rd_rdata_c2", RDATA_o, 32'h8C22_0004);
    chk("rd_as_n_c2",  32'(AS_N), 32'd1);
    REQ = 1'b0; MR = 1'b0; ACK_N = 1'b1;
    tick();
    chk("rd_idle_c3", 32'(STATE_o), 32'd0);

    // Write with acknowledge arriving in cycle 4; busy low only in cycle 5.
    REQ = 1'b1; MW = 1'b1; ADDR_IN = 32'h100; WDATA_IN = 32'hCAFE_F00D;
    for (int c = 0; c <= 5; c++) begin
      ACK_N = (c == 4) ? 1'b0 : 1'b1;
      if (c == 2) begin
        // Controller inputs are ignored once the cycle is under way.
        ADDR_IN = 32'hDEAD_0000; WDATA_IN = 32'h1111_2222; MW = 1'b0;
      end
      #1;
      chk($sformatf("wr_busy_c%0d", c), 32'(busy), (c == 5) ? 32'd0 : 32'd1);
      if (c >= 1 && c <= 4) begin
        chk($sformatf("wr_wr_n_c%0d", c), 32'(WR_N), 32'd0);
        chk($sformatf("wr_do_c%0d", c), DO, 32'hCAFE_F00D);
        chk($sformatf("wr_ao_c%0d", c), AO, 32'h100);
      end
      if (c == 5) begin
        chk("wr_rdata", RDATA_o, 32'h8C22_0004);
        chk("wr_err",   32'(ERR_o), 32'd0);
        REQ = 1'b0; MW = 1'b0; ACK_N = 1'b1;
      end
      tick();
    end

    // Timeout: 16 WAIT cycles, then DONE with the error flag.
    REQ = 1'b1; MR = 1'b1; ADDR_IN = 32'h200; DI = 32'h5555_AAAA;
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (c == 1 || c == 16) chk($sformatf("to_wait_c%0d", c), 32'(STATE_o), 32'd1);
      if (c == 16) chk("to_err_pre", 32'(ERR_o), 32'd0);
      tick();
    end
    chk("to_state_done", 32'(STATE_o), 32'd2);
    chk("to_err",        32'(ERR_o), 32'd1);
    chk("to_rdata_kept", RDATA_o, 32'h8C22_0004);
    chk("to_as_n",       32'(AS_N), 32'd1);
    chk("to_busy",       32'(busy), 32'd0);
    REQ = 1'b0;
    tick();

    // Good read after timeout: error stays sticky.
    REQ = 1'b1; ADDR_IN = 32'h204; DI = 32'h1234_5678;
    tick();
    ACK_N = 1'b0;
    tick();
    chk("gr_rdata", RDATA_o, 32'h1234_5678);
    chk("gr_err",   32'(ERR_o), 32'd1);
    REQ = 1'b0; ACK_N = 1'b1;
    tick();

    // Stale acknowledge held while REQ rises.
    REQ = 1'b1; ACK_N = 1'b0; ADDR_IN = 32'h208;
    for (int c = 0; c <= 2; c++) begin
      #1;
      chk($sformatf("st_state_c%0d", c), 32'(STATE_o), 32'd0);
      chk($sformatf("st_busy_c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("st_as_n_c%0d", c), 32'(AS_N), 32'd1);
      tick();
    end
    ACK_N = 1'b1;
    tick();
    chk("st_wait_c4", 32'(STATE_o), 32'd1);
    chk("st_as_n_c4", 32'(AS_N), 32'd0);
    chk("st_ao_c4",   AO, 32'h208);
    ACK_N = 1'b0;
    tick();
    REQ = 1'b0; ACK_N = 1'b1;
    tick();

    // Fetch then load: two separate strobe pulses, no third.
    begin
      logic [9:0] req_v;
      logic [9:0] ackn_v;
      logic       prev_as;
      int         pulses;
      req_v   = 10'b00_0111_0111; // bit c = REQ in cycle c
      ackn_v  = 10'b11_1101_1101; // acknowledge in cycles 1 and 5
      prev_as = 1'b1;
      pulses  = 0;
      for (int c = 0; c < 10; c++) begin
        REQ     = req_v[c];
        ACK_N   = ackn_v[c];
        ADDR_IN = (c < 3) ? 32'h300 : 32'h304;
        #1;
        if (prev_as && !AS_N) begin
          pulses++;
          chk($sformatf("fl_ao_pulse%0d", pulses), AO, (pulses == 1) ? 32'h300 : 32'h304);
        end
        prev_as = AS_N;
        tick();
      end
      chk("fl_pulses", 32'(pulses), 32'd2);
    end
    REQ = 1'b0; ACK_N = 1'b1;

    // Reset while in WAIT.
    REQ = 1'b1; MW = 1'b1; ADDR_IN = 32'h400; WDATA_IN = 32'h0BAD_BEEF;
    tick();
    chk("rw_wait", 32'(STATE_o), 32'd1);
    RESET = 1'b1;
    tick();
    chk("rw_state", 32'(STATE_o), 32'd0);
    chk("rw_as_n",  32'(AS_N), 32'd1);
    chk("rw_wr_n",  32'(WR_N), 32'd1);
    chk("rw_err",   32'(ERR_o), 32'd0);
    chk("rw_rdata", RDATA_o, 32'd0);
    chk("rw_busy",  32'(busy), 32'd1);
    REQ = 1'b0;
    #1 chk("rw_busy_noreq", 32'(busy), 32'd0);
    RESET = 1'b0; MW = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
